// File: rtl/pc_ctrl.sv
// Fetch-stage program counter: next-PC selection, EPC capture, misaligned
// control-flow detection and a small circular return-address stack.
module pc_ctrl #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
  parameter int unsigned     RAS_DEPTH    = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            en,
  input  logic            branch_taken,
  input  logic            jal_en,
  input  logic            jalr_en,
  input  logic [XLEN-1:0] rs1_value,
  input  logic [XLEN-1:0] imm,
  input  logic            auipc_en,
  input  logic            ras_push,
  input  logic            ras_pop,
  input  logic            trap_req,
  input  logic            trap_ret,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc_add_out,
  output logic [XLEN-1:0] epc_out,
  output logic            redirect,
  output logic            misaligned_fault,
  output logic [XLEN-1:0] ras_top,
  output logic            ras_valid
);

  localparam int unsigned     PTR_W    = $clog2(RAS_DEPTH);
  localparam int unsigned     CNT_W    = $clog2(RAS_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

  logic [XLEN-1:0]  pc, pc_nxt;
  logic [XLEN-1:0]  epc, epc_nxt;
  logic             redirect_q, redirect_nxt;
  logic             fault_q, fault_nxt;
  logic [XLEN-1:0]  ras_mem [RAS_DEPTH];
  logic [XLEN-1:0]  ras_mem_nxt [RAS_DEPTH];
  logic [PTR_W-1:0] ras_ptr, ras_ptr_nxt, ras_ptr_inc;
  logic [CNT_W-1:0] ras_cnt, ras_cnt_nxt;

  logic [XLEN-1:0]  pc_plus4, pc_plus_imm, jalr_tgt, cf_tgt;
  logic             cf_sel, cf_misaligned, ras_upd;

  // Shared adders and control-flow target selection
  always_comb begin
    pc_plus4      = pc + XLEN'(4);
    pc_plus_imm   = pc + imm;
    jalr_tgt      = (rs1_value + imm) & ~XLEN'(1);
    cf_sel        = jalr_en | jal_en | branch_taken;
    cf_tgt        = jalr_en ? jalr_tgt : pc_plus_imm;
    cf_misaligned = cf_sel && (cf_tgt[1:0] != 2'b00);
    ras_upd       = en && !trap_req && !trap_ret;
  end

  // Next PC / EPC; a trap request is honoured even while stalled
  always_comb begin
    pc_nxt       = pc;
    epc_nxt      = epc;
    redirect_nxt = 1'b0;
    fault_nxt    = 1'b0;
    if (trap_req) begin
      pc_nxt       = TRAP_VECTOR;
      epc_nxt      = pc;
      redirect_nxt = 1'b1;
    end else if (en) begin
      if (trap_ret) begin
        pc_nxt       = epc;
        redirect_nxt = 1'b1;
      end else if (cf_misaligned) begin
        pc_nxt       = TRAP_VECTOR;
        epc_nxt      = cf_tgt;
        redirect_nxt = 1'b1;
        fault_nxt    = 1'b1;
      end else if (cf_sel) begin
        pc_nxt       = cf_tgt;
        redirect_nxt = 1'b1;
      end else begin
        pc_nxt = pc_plus4;
      end
    end
  end

  // Return-address stack; push+pop on a non-empty stack replaces the top
  always_comb begin
    ras_mem_nxt = ras_mem;
    ras_ptr_nxt = ras_ptr;
    ras_cnt_nxt = ras_cnt;
    ras_ptr_inc = ras_ptr + PTR_W'(1);
    if (ras_upd) begin
      if (ras_push && (!ras_pop || ras_cnt == '0)) begin
        ras_mem_nxt[ras_ptr_inc] = pc_plus4;
        ras_ptr_nxt              = ras_ptr_inc;
        if (ras_cnt != CNT_FULL) ras_cnt_nxt = ras_cnt + CNT_W'(1);
      end else if (ras_push) begin
        ras_mem_nxt[ras_ptr] = pc_plus4;
      end else if (ras_pop && ras_cnt != '0) begin
        ras_ptr_nxt = ras_ptr - PTR_W'(1);
        ras_cnt_nxt = ras_cnt - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc         <= RESET_VECTOR;
      epc        <= '0;
      redirect_q <= 1'b0;
      fault_q    <= 1'b0;
      ras_ptr    <= '0;
      ras_cnt    <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) ras_mem[i] <= '0;
    end else begin
      pc         <= pc_nxt;
      epc        <= epc_nxt;
      redirect_q <= redirect_nxt;
      fault_q    <= fault_nxt;
      ras_ptr    <= ras_ptr_nxt;
      ras_cnt    <= ras_cnt_nxt;
      ras_mem    <= ras_mem_nxt;
    end
  end

  assign pc_out           = pc;
  assign pc_add_out       = auipc_en ? pc_plus_imm : pc_plus4;
  assign epc_out          = epc;
  assign redirect         = redirect_q;
  assign misaligned_fault = fault_q;
  assign ras_valid        = (ras_cnt != '0);
  assign ras_top          = (ras_cnt != '0) ? ras_mem[ras_ptr] : '0;

endmodule

// File: tb/tb_pc_ctrl.sv
// Self-checking bench for pc_ctrl: a behavioural model pushes the expected
// architectural state each cycle; the DUT state is popped and compared after the edge.
module tb_pc_ctrl;

  localparam logic [31:0] TRAP = 32'h0000_0100;
  localparam int          DEPTH = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] epc;
    logic [31:0] top;
    logic        redirect;
    logic        fault;
    logic        valid;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        en, branch_taken, jal_en, jalr_en, auipc_en;
  logic        ras_push, ras_pop, trap_req, trap_ret;
  logic [31:0] rs1_value, imm;
  logic [31:0] pc_out, pc_add_out, epc_out, ras_top;
  logic        redirect, misaligned_fault, ras_valid;

  exp_t        obs;
  exp_t        sb[$];
  logic [31:0] m_pc, m_epc;
  logic [31:0] m_ras[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  pc_ctrl #(
    .XLEN(32), .RESET_VECTOR(32'h0), .TRAP_VECTOR(TRAP), .RAS_DEPTH(DEPTH)
  ) dut (
    .clock(clock), .reset(reset), .en(en), .branch_taken(branch_taken),
    .jal_en(jal_en), .jalr_en(jalr_en), .rs1_value(rs1_value), .imm(imm),
    .auipc_en(auipc_en), .ras_push(ras_push), .ras_pop(ras_pop),
    .trap_req(trap_req), .trap_ret(trap_ret), .pc_out(pc_out),
    .pc_add_out(pc_add_out), .epc_out(epc_out), .redirect(redirect),
    .misaligned_fault(misaligned_fault), .ras_top(ras_top), .ras_valid(ras_valid)
  );

  always #5 clock = ~clock;

  assign obs = {pc_out, epc_out, ras_top, redirect, misaligned_fault, ras_valid};

  task automatic idle(input logic e);
    en = e; branch_taken = 0; jal_en = 0; jalr_en = 0; auipc_en = 0;
    ras_push = 0; ras_pop = 0; trap_req = 0; trap_ret = 0;
    rs1_value = '0; imm = '0;
  endtask

  task automatic model_reset();
    m_pc = '0; m_epc = '0; m_ras.delete(); sb.delete();
  endtask

  // Model one edge from the current inputs, queue the expectation, advance the clock
  task automatic cycle();
    exp_t        e;
    logic [31:0] tgt, p4;
    logic        sel;
    p4  = m_pc + 32'd4;
    sel = jalr_en | jal_en | branch_taken;
    tgt = jalr_en ? ((rs1_value + imm) & 32'hFFFF_FFFE) : (m_pc + imm);
    e.redirect = 1'b0;
    e.fault    = 1'b0;
    if (en && !trap_req && !trap_ret) begin
      if (ras_push && ras_pop && m_ras.size() != 0) m_ras[m_ras.size()-1] = p4;
      else if (ras_push) begin
        m_ras.push_back(p4);
        if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
      end else if (ras_pop && m_ras.size() != 0) void'(m_ras.pop_back());
    end
    if (trap_req) begin
      m_epc = m_pc; m_pc = TRAP; e.redirect = 1'b1;
    end else if (en) begin
      if (trap_ret) begin
        m_pc = m_epc; e.redirect = 1'b1;
      end else if (sel && tgt[1:0] != 2'b00) begin
        m_epc = tgt; m_pc = TRAP; e.redirect = 1'b1; e.fault = 1'b1;
      end else if (sel) begin
        m_pc = tgt; e.redirect = 1'b1;
      end else m_pc = p4;
    end
    e.pc    = m_pc;
    e.epc   = m_epc;
    e.valid = (m_ras.size() != 0);
    e.top   = (m_ras.size() != 0) ? m_ras[m_ras.size()-1] : 32'h0;
    sb.push_back(e);
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic jump_to(input logic [31:0] tgt);
    idle(1'b1); jal_en = 1'b1; imm = tgt - m_pc;
    cycle();
    idle(1'b1);
  endtask

  task automatic test_reset();
    exp_t e;
    reset = 1'b1; idle(1'b0); model_reset();
    repeat (2) @(negedge clock);
    e = '0;
    n_tests++;
    if (obs !== e) begin n_fail++; $display("FAIL reset_state: got %h exp %h", obs, e); end
    reset = 1'b0;
  endtask

  task automatic test_sequential();
    exp_t e;
    idle(1'b1);
    for (int i = 1; i <= 3; i++) begin
      cycle();
      e = sb.pop_front();
      n_tests++;
      if (obs !== e) begin n_fail++; $display("FAIL seq[%0d]: got %h exp %h", i, obs, e); end
      n_tests++;
      if (pc_out !== 32'(4 * i) || redirect !== 1'b0 || ras_valid !== 1'b0) begin
        n_fail++; $display("FAIL seq_pc[%0d]: got pc=%h rd=%b rv=%b exp pc=%h rd=0 rv=0",
                           i, pc_out, redirect, ras_valid, 32'(4 * i));
      end
    end
  endtask

  task automatic test_branch_stall();
    exp_t e;
    jump_to(32'h40);
    e = sb.pop_front();
    n_tests++;
    if (obs !== e) begin n_fail++; $display("FAIL br_setup: got %h exp %h", obs, e); end
    branch_taken = 1'b1; imm = 32'hFFFF_FFF0;
    cycle();
    e = sb.pop_front();
    n_tests++;
    if (obs !== e || pc_out !== 32'h30 || redirect !== 1'b1) begin
      n_fail++; $display("FAIL branch: got %h exp %h (pc 30 redirect 1)", obs, e);
    end
    idle(1'b0);
    for (int i = 0; i < 2; i++) begin
      cycle();
      e = sb.pop_front();
      n_tests++;
      if (obs !== e || pc_out !== 32'h30 || redirect !== 1'b0) begin
        n_fail++; $display("FAIL stall[%0d]: got %h exp %h (pc 30 redirect 0)", i, obs, e);
      end
    end
  endtask

  task automatic test_misaligned();
    exp_t e;
    jump_to(32'h20);
    e = sb.pop_front();
    n_tests++;
    if (obs !== e) begin n_fail++; $display("FAIL mis_setup: got %h exp %h", obs, e); end
    jalr_en = 1'b1; rs1_value = 32'h1003; imm = '0;
    cycle();
    e = sb.pop_front();
    n_tests++;
    if (obs !== e || pc_out !== TRAP || epc_out !== 32'h1002 || misaligned_fault !== 1'b1) begin
      n_fail++; $display("FAIL jalr_misaligned: got %h exp %h", obs, e);
    end
    idle(1'b1); trap_ret = 1'b1;
    cycle();
    e = sb.pop_front();
    n_tests++;
    if (obs !== e || pc_out !== 32'h1002 || misaligned_fault !== 1'b0) begin
      n_fail++; $display("FAIL trap_ret: got %h exp %h", obs, e);
    end
    idle(1'b1);
  endtask

  task automatic test_ras();
    exp_t        e;
    logic [31:0] pops [4];
    pops = '{32'h14, 32'h10, 32'hC, 32'h8};
    jump_to(32'h0);
    e = sb.pop_front();
    n_tests++;
    if (obs !== e) begin n_fail++; $display("FAIL ras_setup: got %h exp %h", obs, e); end
    for (int i = 0; i < 5; i++) begin
      ras_push = 1'b1;
      cycle();
      e = sb.pop_front();
      n_tests++;
      if (obs !== e) begin n_fail++; $display("FAIL push[%0d]: got %h exp %h", i, obs, e); end
    end
    n_tests++;
    if (ras_top !== 32'h14 || ras_valid !== 1'b1) begin
      n_fail++; $display("FAIL ras_full_top: got %h/%b exp 00000014/1", ras_top, ras_valid);
    end
    idle(1'b1);
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin
        n_tests++;
        if (ras_top !== pops[i]) begin
          n_fail++; $display("FAIL pop_val[%0d]: got %h exp %h", i, ras_top, pops[i]);
        end
      end
      ras_pop = 1'b1;
      cycle();
      e = sb.pop_front();
      n_tests++;
      if (obs !== e) begin n_fail++; $display("FAIL pop[%0d]: got %h exp %h", i, obs, e); end
    end
    n_tests++;
    if (ras_valid !== 1'b0 || ras_top !== 32'h0) begin
      n_fail++; $display("FAIL ras_empty: got %h/%b exp 00000000/0", ras_top, ras_valid);
    end
    // push+pop on empty acts as push, then on non-empty replaces the top
    for (int i = 0; i < 2; i++) begin
      ras_push = 1'b1; ras_pop = 1'b1;
      cycle();
      e = sb.pop_front();
      n_tests++;
      if (obs !== e || ras_valid !== 1'b1 || ras_top !== pc_out) begin
        n_fail++; $display("FAIL push_pop[%0d]: got %h exp %h", i, obs, e);
      end
    end
    idle(1'b1);
  endtask

  task automatic test_trap();
    exp_t e;
    jump_to(32'h80);
    e = sb.pop_front();
    n_tests++;
    if (obs !== e) begin n_fail++; $display("FAIL trap_setup: got %h exp %h", obs, e); end
    trap_req = 1'b1; jal_en = 1'b1; ras_push = 1'b1; imm = 32'h2;
    cycle();
    e = sb.pop_front();
    n_tests++;
    if (obs !== e || pc_out !== TRAP || epc_out !== 32'h80 || misaligned_fault !== 1'b0) begin
      n_fail++; $display("FAIL trap_over_jal: got %h exp %h", obs, e);
    end
    idle(1'b0); trap_req = 1'b1;
    cycle();
    e = sb.pop_front();
    n_tests++;
    if (obs !== e || pc_out !== TRAP || epc_out !== TRAP || redirect !== 1'b1) begin
      n_fail++; $display("FAIL trap_stalled: got %h exp %h", obs, e);
    end
    idle(1'b1);
  endtask

  task automatic test_wrap_auipc();
    exp_t e;
    jump_to(32'hFFFF_FFFC);
    e = sb.pop_front();
    n_tests++;
    if (obs !== e) begin n_fail++; $display("FAIL wrap_setup: got %h exp %h", obs, e); end
    cycle();
    e = sb.pop_front();
    n_tests++;
    if (obs !== e || pc_out !== 32'h0) begin
      n_fail++; $display("FAIL wrap: got %h exp %h", obs, e);
    end
    auipc_en = 1'b1; imm = 32'h1000;
    #1;
    n_tests++;
    if (pc_add_out !== 32'h1000) begin
      n_fail++; $display("FAIL auipc: got %h exp 00001000", pc_add_out);
    end
    auipc_en = 1'b0;
    #1;
    n_tests++;
    if (pc_add_out !== 32'h4) begin
      n_fail++; $display("FAIL pc_plus4: got %h exp 00000004", pc_add_out);
    end
    idle(1'b1);
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int i = 0; i < 300; i++) begin
      en           = ($urandom_range(0, 3) != 0);
      branch_taken = ($urandom_range(0, 5) == 0);
      jal_en       = ($urandom_range(0, 7) == 0);
      jalr_en      = ($urandom_range(0, 7) == 0);
      auipc_en     = $urandom_range(0, 1) != 0;
      ras_push     = ($urandom_range(0, 3) == 0);
      ras_pop      = ($urandom_range(0, 3) == 0);
      trap_req     = ($urandom_range(0, 15) == 0);
      trap_ret     = ($urandom_range(0, 15) == 0);
      rs1_value    = $urandom;
      imm          = $urandom & 32'h0000_FFFC;
      if ($urandom_range(0, 7) == 0) imm = imm | 32'($urandom_range(1, 3));
      cycle();
      e = sb.pop_front();
      n_tests++;
      if (obs !== e) begin n_fail++; $display("FAIL rand[%0d]: got %h exp %h", i, obs, e); end
    end
    idle(1'b1);
  endtask

  task automatic test_reset_mid();
    exp_t e;
    jump_to(32'h200);
    e = sb.pop_front();
    n_tests++;
    if (obs !== e || redirect !== 1'b1) begin
      n_fail++; $display("FAIL mid_setup: got %h exp %h", obs, e);
    end
    #2 reset = 1'b1;
    model_reset();
    #1;
    e = '0;
    n_tests++;
    if (obs !== e) begin n_fail++; $display("FAIL reset_mid: got %h exp %h", obs, e); end
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch_stall();
    test_misaligned();
    test_ras();
    test_trap();
    test_wrap_auipc();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_ctrl.md
Name: pc_ctrl

Overview:
- Parametrised program-counter unit for the rv32 core fetch stage; successor to the single-width PC register.
- Generates the next fetch address from sequential, branch, JAL/JALR, trap-entry and trap-return sources, and latches the exception PC (EPC).
- Flags misaligned control-flow targets.
- Holds a small return-address stack (RAS) that predicts function returns.

Parameters:
- XLEN, 32, datapath and address width.
- RESET_VECTOR, 0, PC value loaded on reset.
- TRAP_VECTOR, 32'h0000_0100, PC loaded on trap entry or misaligned fault.
- RAS_DEPTH, 4, return-address-stack entries; power of two, at least 2.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- en  in  1  advance PC this cycle; 0 = stall
- branch_taken  in  1  conditional branch resolved taken
- jal_en  in  1  JAL; target = pc + imm
- jalr_en  in  1  JALR; target = (rs1_value + imm) & ~1
- rs1_value  in  XLEN  JALR base register
- imm  in  XLEN  sign-extended byte offset, already shifted
- auipc_en  in  1  select pc+imm on pc_add_out
- ras_push  in  1  call; push pc+4
- ras_pop  in  1  return; pop top entry
- trap_req  in  1  synchronous trap request
- trap_ret  in  1  MRET; resume at EPC
- pc_out  out  XLEN  current PC
- pc_add_out  out  XLEN  auipc_en ? pc+imm : pc+4 (combinational)
- epc_out  out  XLEN  saved exception PC
- redirect  out  1  registered; PC was loaded non-sequentially last edge (pipeline flush)
- misaligned_fault  out  1  registered one-cycle pulse
- ras_top  out  XLEN  predicted return address
- ras_valid  out  1  RAS non-empty

Behaviour:
- Reset values: pc_out=RESET_VECTOR; epc_out=0; redirect=0; misaligned_fault=0; ras_valid=0; ras_top=0. RAS pointer and count are cleared. Reset asserted mid-operation discards any pending redirect.
- When en=0: no state changes, with one exception: trap_req is still honoured. redirect and misaligned_fault go to 0 after the first stalled edge.
- Next-PC priority when en=1, highest first:
  1. trap_req: pc←TRAP_VECTOR; epc←pc.
  2. trap_ret: pc←epc.
  3. Misaligned target: the selected jal/jalr/branch target has bits[1:0]≠0. Then pc←TRAP_VECTOR, epc←faulting target, misaligned_fault=1 next cycle.
  4. jalr_en: pc←(rs1_value+imm)&~1.
  5. jal_en or branch_taken: pc←pc+imm.
  6. Otherwise: pc←pc+4.
- redirect=1 for one cycle after any of sources 1–5 loads the PC.
- Arithmetic: all sums are modulo 2^XLEN; wrap-around is silent. pc+4 at 0xFFFF_FFFC gives 0.
- RAS storage is a circular buffer with a top pointer and a saturating count (0..RAS_DEPTH). It updates only when en=1 and no trap_req/trap_ret is active.
- RAS push only: write pc+4 at top+1, advance top, count=min(count+1, RAS_DEPTH). When full, the oldest entry is overwritten silently.
- RAS pop only: if count>0, retreat top and decrement count. Pop when empty is ignored.
- RAS push and pop together: overwrite the top entry with pc+4; pointer and count are unchanged. If empty, this behaves as a push.
- ras_top = entry[top] when count>0, else 0. ras_valid = (count≠0).
- misaligned_fault and trap_req in the same cycle: trap_req wins, no fault pulse.

Test Plan:
- Reset release, en=1 for 3 cycles -> pc_out 0,4,8,12; redirect=0; ras_valid=0.
- pc=0x40, branch_taken, imm=0xFFFF_FFF0 -> pc=0x30, redirect=1 for one cycle. Then en=0 for 2 cycles -> pc holds at 0x30.
- pc=0x20, jalr_en, rs1=0x1003, imm=0 -> pc=0x1002 is misaligned -> pc=0x100, epc=0x1002, misaligned_fault pulse. Next cycle trap_ret -> pc=0x1002.
- Push 5 times at pcs 0x0,0x4,0x8,0xC,0x10 with RAS_DEPTH=4 -> ras_top=0x14. Then 4 pops yield 0x14,0x10,0xC,0x8, ras_valid=0; a 5th pop leaves ras_valid=0.
- trap_req with jal_en, pc=0x80 -> pc=0x100, epc=0x80, no RAS change, no fault. Also trap_req with en=0 -> still taken.
- pc=0xFFFF_FFFC, en=1 -> pc=0. auipc_en, imm=0x1000, pc=0 -> pc_add_out=0x1000.
